// File: rtl/barrett_pkg.sv
// Shared types and width helpers for the Barrett reducer.
// Imported by barrett_lane and barrett_reduce_pipe.
package barrett_pkg;

  localparam int PIPE_STAGES = 4;

  typedef enum logic [1:0] {
    UNCONF,
    DRAIN,
    DIV,
    RUN
  } state_e;

  function automatic int mu_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int r_width(input int qw);
    return qw + 2;
  endfunction

endpackage

// File: rtl/barrett_lane.sv
// One lane of the 4-stage Barrett datapath.
// All stages move together on adv; S1 loads only real beats.
module barrett_lane
  import barrett_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int Q_WIDTH    = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [DATA_WIDTH:0]   mu,
  input  logic [Q_WIDTH-1:0]    q,
  output logic [Q_WIDTH-1:0]    res
);

  localparam int MW = mu_width(DATA_WIDTH);
  localparam int RW = r_width(Q_WIDTH);
  localparam int PW = DATA_WIDTH + MW;

  logic [PW-1:0] p_c;
  logic [MW-1:0] qe1;
  logic [RW-1:0] x1;
  logic [RW-1:0] x2;
  logic [RW-1:0] m2;
  logic [RW-1:0] r3;
  logic [RW-1:0] q_ext;
  logic [RW-1:0] r_a;
  logic [RW-1:0] r_b;

  // Only the low RW bits of x and m matter: x - m < 3Q.
  always_comb begin
    p_c   = PW'(x) * PW'(mu);
    q_ext = RW'(q);
    r_a   = (r3 >= q_ext) ? r3 - q_ext : r3;
    r_b   = (r_a >= q_ext) ? r_a - q_ext : r_a;
  end

  // S1 keeps the product bits above K; later stages follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      qe1 <= '0;
      x1  <= '0;
      x2  <= '0;
      m2  <= '0;
      r3  <= '0;
      res <= '0;
    end else if (adv) begin
      if (valid) begin
        qe1 <= MW'(p_c >> DATA_WIDTH);
        x1  <= RW'(x);
      end
      m2  <= RW'(qe1 * MW'(q));
      x2  <= x1;
      r3  <= x2 - m2;
      res <= Q_WIDTH'(r_b);
    end
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Streaming multi-lane Barrett reducer with on-chip mu divider.
// Optional sideband tag: define BARRETT_TAG_EN.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int DATA_WIDTH = 48,
  parameter int Q_WIDTH    = 23,
  parameter int LANES      = 4,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  input  logic [Q_WIDTH-1:0]            cfg_q,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_err,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
`ifdef BARRETT_TAG_EN
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic [TAG_WIDTH-1:0]          out_tag,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*Q_WIDTH-1:0]      out_data
);

  localparam int MW = mu_width(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  state_e                 state;
  logic                   mu_valid;
  logic [MW-1:0]          mu;
  logic [Q_WIDTH-1:0]     q_pend;
  logic [Q_WIDTH-1:0]     q_run;
  logic [Q_WIDTH-1:0]     rem;
  logic [CW-1:0]          cnt;
  logic [PIPE_STAGES-1:0] vld;
  logic                   adv;
  logic                   fire;
  logic                   pipe_empty;
  logic [Q_WIDTH:0]       rem_sh;
  logic [Q_WIDTH:0]       rem_sub;
  logic                   ge;

  // Handshake and one restoring-divider step on 2^K.
  always_comb begin
    adv        = !vld[PIPE_STAGES-1] || out_ready;
    in_ready   = (state == RUN) && mu_valid && adv;
    fire       = in_valid && in_ready;
    pipe_empty = ~|vld;
    cfg_busy   = (state == DRAIN) || (state == DIV);
    out_valid  = vld[PIPE_STAGES-1];
    rem_sh     = {rem, cnt == CW'(DATA_WIDTH)};
    rem_sub    = rem_sh - {1'b0, q_run};
    ge         = rem_sh >= {1'b0, q_run};
  end

  // Config FSM: drain old beats, divide, then run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNCONF;
      mu_valid <= 1'b0;
      mu       <= '0;
      q_pend   <= '0;
      q_run    <= '0;
      rem      <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      unique case (state)
        UNCONF, RUN: begin
          if (cfg_start) begin
            mu_valid <= 1'b0;
            if (cfg_q < Q_WIDTH'(2)) begin
              cfg_err <= 1'b1;
              state   <= UNCONF;
            end else begin
              q_pend  <= cfg_q;
              cfg_err <= 1'b0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pipe_empty) begin
            q_run <= q_pend;
            rem   <= '0;
            mu    <= '0;
            cnt   <= CW'(DATA_WIDTH);
            state <= DIV;
          end
        end
        DIV: begin
          rem <= ge ? Q_WIDTH'(rem_sub) : Q_WIDTH'(rem_sh);
          mu  <= {mu[MW-2:0], ge};
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state    <= RUN;
            mu_valid <= 1'b1;
            cfg_done <= 1'b1;
          end
        end
        default: state <= UNCONF;
      endcase
    end
  end

  // Stage valids shift together with the lane data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (adv) begin
      vld <= {vld[PIPE_STAGES-2:0], fire};
    end
  end

`ifdef BARRETT_TAG_EN
  logic [TAG_WIDTH-1:0] tag_pipe [PIPE_STAGES];

  // Tags ride alongside the beat with identical stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        tag_pipe[i] <= '0;
      end
    end else if (adv) begin
      tag_pipe[0] <= in_tag;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign out_tag = tag_pipe[PIPE_STAGES-1];
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    barrett_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .Q_WIDTH   (Q_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .adv  (adv),
      .valid(fire),
      .x    (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .mu   (mu),
      .q    (q_run),
      .res  (out_data[i*Q_WIDTH +: Q_WIDTH])
    );
  end

endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// Directed/table bench for barrett_reduce_pipe.
// Scoreboard checks every output beat against x mod Q.
module tb_barrett_reduce_pipe;

  localparam int DW = 48;
  localparam int QW = 23;
  localparam int L  = 4;
  localparam int TW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [QW-1:0]   cfg_q;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_err;
  logic            in_valid;
  logic            in_ready;
  logic [L*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [L*QW-1:0] out_data;
`ifdef BARRETT_TAG_EN
  logic [TW-1:0]   in_tag;
  logic [TW-1:0]   out_tag;
  logic [TW-1:0]   exp_t [$];
`endif

  always #5 clk = ~clk;

  barrett_reduce_pipe #(
    .DATA_WIDTH(DW),
    .Q_WIDTH   (QW),
    .LANES     (L),
    .TAG_WIDTH (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_start(cfg_start),
    .cfg_q    (cfg_q),
    .cfg_busy (cfg_busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
`ifdef BARRETT_TAG_EN
    .in_tag   (in_tag),
    .out_tag  (out_tag),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  typedef struct {
    logic [QW-1:0]   q;
    logic [L*DW-1:0] x;
    logic [L*QW-1:0] r;
  } vec_t;

  vec_t            vecs [3];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              out_cnt = 0;
  logic [QW-1:0]   cur_q   = '0;
  logic [L*QW-1:0] exp_q [$];

  function automatic logic [L*QW-1:0] model(
    input logic [L*DW-1:0] x,
    input logic [QW-1:0]   q
  );
    logic [L*QW-1:0] r;
    logic [63:0]     xv;
    r = '0;
    for (int i = 0; i < L; i++) begin
      xv = 64'(x[i*DW +: DW]);
      r[i*QW +: QW] = QW'(xv % 64'(q));
    end
    return r;
  endfunction

  function automatic logic [L*DW-1:0] rand_beat();
    logic [L*DW-1:0] b;
    for (int i = 0; i < L; i++) begin
      b[i*DW +: DW] = DW'({$urandom, $urandom});
    end
    return b;
  endfunction

  task automatic check(
    input string        nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
`ifdef BARRETT_TAG_EN
      exp_t.delete();
`endif
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data, cur_q));
`ifdef BARRETT_TAG_EN
        exp_t.push_back(in_tag);
`endif
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_extra: got %0h expected none", out_data);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
`ifdef BARRETT_TAG_EN
          check("sb_tag", out_tag, exp_t.pop_front());
`endif
        end
      end
    end
  end

  task automatic cfg(
    input  logic [QW-1:0] q,
    input  int            exp_lat,
    output int            lat
  );
    cfg_start = 1'b1;
    cfg_q     = q;
    tick();
    cfg_start = 1'b0;
    if (q >= 2) cur_q = q;
    check("cfg_in_ready_drop", in_ready, 1'b0);
    lat = 0;
    if (exp_lat > 0) begin
      lat = 1;
      while (!cfg_done && lat < 300) begin
        tick();
        lat++;
      end
      check("cfg_done_lat", lat, exp_lat);
      check("cfg_err_clear", cfg_err, 1'b0);
    end
  endtask

  task automatic send_lat(
    input logic [L*DW-1:0] x,
    input logic [L*QW-1:0] r
  );
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = x;
`ifdef BARRETT_TAG_EN
    in_tag    = TW'($urandom);
`endif
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("beat_latency", n, 4);
    check("beat_data", out_data, r);
  endtask

  initial begin
    int              lat;
    int              oc0;
    int              cyc;
    int              seen;
    bit              fired;
    logic [L*DW-1:0] beats [100];

    rst       = 1'b1;
    cfg_start = 1'b0;
    cfg_q     = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef BARRETT_TAG_EN
    in_tag    = '0;
`endif

    vecs[0].q = 23'd3329;
    vecs[0].x = {48'd11082240, 48'd3329, 48'd0, 48'd65536};
    vecs[0].r = {23'd3328, 23'd0, 23'd0, 23'd2285};
    vecs[1].q = 23'd4591;
    vecs[1].x = {48'd9183, 48'd4591, 48'd4590, 48'd10000};
    vecs[1].r = {23'd1, 23'd0, 23'd4590, 23'd818};
    vecs[2].q = 23'd8380417;
    vecs[2].x = {48'hFFFF_FFFF_FFFF, 48'd8380418,
                 48'd8380416, 48'd16777216};
    vecs[2].r = {QW'(64'hFFFF_FFFF_FFFF % 64'd8380417),
                 23'd1, 23'd8380416, 23'd16382};

    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_busy", cfg_busy, 1'b0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
`ifdef BARRETT_TAG_EN
    check("rst_tag", out_tag, '0);
`endif
    rst = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      cfg(vecs[v].q, 51, lat);
      tick();
      send_lat(vecs[v].x, vecs[v].r);
      repeat (3) tick();
    end

    // Three beats in flight under old Q when reconfiguring.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = rand_beat();
`ifdef BARRETT_TAG_EN
      in_tag   = TW'($urandom);
`endif
      tick();
    end
    in_valid = 1'b0;
    oc0 = out_cnt;
    cfg(23'd4591, 54, lat);
    check("inflight_drained", out_cnt - oc0, 3);
    tick();

    // Stream under random backpressure.
    for (int i = 0; i < 100; i++) beats[i] = rand_beat();
    beats[0][DW-1:0]      = 48'd10000;
    beats[1][DW-1:0]      = 48'hFFFF_FFFF_FFFF;
    beats[1][2*DW-1:DW]   = 48'd4591;
    oc0 = out_cnt;
    cyc = 0;
    for (int i = 0; i < 100 && cyc < 3000;) begin
      in_valid  = 1'b1;
      in_data   = beats[i];
`ifdef BARRETT_TAG_EN
      in_tag    = TW'(i);
`endif
      out_ready = ($urandom_range(0, 99) >= 30);
      @(negedge clk);
      fired = in_valid && in_ready;
      tick();
      cyc++;
      if (fired) i++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("stream_count", out_cnt - oc0, 100);
    check("stream_left", exp_q.size(), 0);

    // Bad modulus then recovery.
    cfg(23'd1, 0, lat);
    check("err_set", cfg_err, 1'b1);
    check("err_in_ready", in_ready, 1'b0);
    seen = 0;
    repeat (60) begin
      tick();
      if (cfg_done || in_ready) seen++;
    end
    check("err_no_done", seen, 0);
    cfg(23'd3329, 51, lat);
    tick();
    send_lat(vecs[0].x, vecs[0].r);
    repeat (3) tick();

    // Reset in the middle of DIV.
    cfg_start = 1'b1;
    cfg_q     = 23'd4591;
    tick();
    cfg_start = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rdiv_out_valid", out_valid, 1'b0);
    check("rdiv_in_ready", in_ready, 1'b0);
    check("rdiv_busy", cfg_busy, 1'b0);
    seen = 0;
    repeat (60) begin
      tick();
      if (cfg_done || in_ready) seen++;
    end
    check("rdiv_stay_unconf", seen, 0);

    // Reset mid-stream with a stalled output.
    cfg(23'd4591, 51, lat);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    cyc = 0;
    while (cyc < 10) begin
      in_data = rand_beat();
`ifdef BARRETT_TAG_EN
      in_tag  = TW'($urandom);
`endif
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstr_out_valid", out_valid, 1'b0);
    check("rstr_out_data", out_data, '0);
    check("rstr_in_ready", in_ready, 1'b0);
    check("rstr_busy", cfg_busy, 1'b0);
`ifdef BARRETT_TAG_EN
    check("rstr_tag", out_tag, '0);
`endif
    out_ready = 1'b1;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
